// File: rtl/mem_access_unit.sv
// mem_access_unit: request/done memory access unit driving split byte-lane banks,
// with alignment faults, wait states and data watchpoints.
module mem_access_unit #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int WP_COUNT    = 2,
  parameter int WPI_W       = (WP_COUNT > 1) ? $clog2(WP_COUNT) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req,
  output logic              ready,
  input  logic              wr,
  input  logic              byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              done,
  output logic              fault,
  output logic [15:0]       rdata,
  output logic              wp_hit,
  output logic [WPI_W-1:0]  wp_idx,
  input  logic              wp_we,
  input  logic [WPI_W-1:0]  wp_sel,
  input  logic [ADDR_W-1:0] wp_addr,
  input  logic              wp_en,
  output logic [ADDR_W-2:0] mem_lb_addr,
  output logic [ADDR_W-2:0] mem_ub_addr,
  output logic [7:0]        mem_lb_wdata,
  output logic [7:0]        mem_ub_wdata,
  output logic              mem_lb_we,
  output logic              mem_ub_we,
  input  logic [7:0]        mem_lb_rdata,
  input  logic [7:0]        mem_ub_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [4:0] cnt;
  logic a0_q, wr_q, be_q, hit_q;
  logic [WPI_W-1:0] idx_q;
  logic [ADDR_W-1:0] wp_a [WP_COUNT];
  logic [WP_COUNT-1:0] wp_v;
  logic hit;
  logic [WPI_W-1:0] hidx;
  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit = 1'b0;
    hidx = '0;
    for (int i = WP_COUNT - 1; i >= 0; i--)
      if (wp_v[i] && (byte_en ? wp_a[i] == addr : wp_a[i][ADDR_W-1:1] == addr[ADDR_W-1:1])) begin
        hit = 1'b1;
        hidx = WPI_W'(i);
      end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      ready <= 1'b1;
      done <= 1'b0;
      fault <= 1'b0;
      rdata <= '0;
      wp_hit <= 1'b0;
      wp_idx <= '0;
      cnt <= '0;
      a0_q <= 1'b0;
      wr_q <= 1'b0;
      be_q <= 1'b0;
      hit_q <= 1'b0;
      idx_q <= '0;
      mem_lb_addr <= '0;
      mem_ub_addr <= '0;
      mem_lb_wdata <= '0;
      mem_ub_wdata <= '0;
      mem_lb_we <= 1'b0;
      mem_ub_we <= 1'b0;
      wp_v <= '0;
      for (int i = 0; i < WP_COUNT; i++) wp_a[i] <= '0;
    end else begin
      for (int i = 0; i < WP_COUNT; i++)
        if (wp_we && wp_sel == WPI_W'(i)) begin
          wp_a[i] <= wp_addr;
          wp_v[i] <= wp_en;
        end
      case (state)
        IDLE: if (req) begin
          ready <= 1'b0;
          a0_q <= addr[0];
          wr_q <= wr;
          be_q <= byte_en;
          if (!byte_en && addr[0]) begin
            state <= DONE;
            done <= 1'b1;
            fault <= 1'b1;
            wp_hit <= 1'b0;
          end else begin
            state <= ACCESS;
            cnt <= 5'(WAIT_CYCLES + 1);
            hit_q <= hit;
            idx_q <= hidx;
            mem_lb_addr <= addr[ADDR_W-1:1];
            mem_ub_addr <= addr[ADDR_W-1:1];
            mem_lb_wdata <= wdata[7:0];
            mem_ub_wdata <= byte_en ? wdata[7:0] : wdata[15:8];
            mem_lb_we <= wr && (!byte_en || !addr[0]);
            mem_ub_we <= wr && (!byte_en || addr[0]);
          end
        end
        ACCESS: begin
          mem_lb_we <= 1'b0;
          mem_ub_we <= 1'b0;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state <= DONE;
            done <= 1'b1;
            wp_hit <= hit_q;
            wp_idx <= idx_q;
            if (!wr_q)
              rdata <= be_q ? {8'h00, a0_q ? mem_ub_rdata : mem_lb_rdata} : {mem_ub_rdata, mem_lb_rdata};
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          done <= 1'b0;
          fault <= 1'b0;
          wp_hit <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus random accesses checked against a byte-addressed
// reference memory and watchpoint model.
module tb_mem_access_unit;
  localparam int WC = 3;
  localparam int WP = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic req = 1'b0, wr = 1'b0, byte_en = 1'b0, wp_we = 1'b0, wp_en = 1'b0;
  logic [15:0] addr = '0, wdata = '0, wp_addr = '0;
  logic [0:0] wp_sel = '0;
  logic ready, done, fault, wp_hit, mem_lb_we, mem_ub_we;
  logic [15:0] rdata;
  logic [0:0] wp_idx;
  logic [14:0] mem_lb_addr, mem_ub_addr;
  logic [7:0] mem_lb_wdata, mem_ub_wdata, mem_lb_rdata, mem_ub_rdata;
  logic [7:0] lb_mem [32768];
  logic [7:0] ub_mem [32768];
  logic [7:0] ref_mem [int];
  logic [15:0] wa [WP];
  logic wv [WP];
  logic [15:0] last_rd;
  int passed = 0, total = 0;
  mem_access_unit #(.ADDR_W(16), .WAIT_CYCLES(WC), .WP_COUNT(WP)) dut (
    .Clock(clk), .Reset(rst), .req(req), .ready(ready), .wr(wr), .byte_en(byte_en),
    .addr(addr), .wdata(wdata), .done(done), .fault(fault), .rdata(rdata),
    .wp_hit(wp_hit), .wp_idx(wp_idx), .wp_we(wp_we), .wp_sel(wp_sel),
    .wp_addr(wp_addr), .wp_en(wp_en), .mem_lb_addr(mem_lb_addr),
    .mem_ub_addr(mem_ub_addr), .mem_lb_wdata(mem_lb_wdata), .mem_ub_wdata(mem_ub_wdata),
    .mem_lb_we(mem_lb_we), .mem_ub_we(mem_ub_we), .mem_lb_rdata(mem_lb_rdata),
    .mem_ub_rdata(mem_ub_rdata)
  );
  always #5 clk = ~clk;
  // Synchronous banks: address registered on the edge, data valid the next cycle.
  always @(posedge clk) begin
    if (mem_lb_we) lb_mem[mem_lb_addr] <= mem_lb_wdata;
    if (mem_ub_we) ub_mem[mem_ub_addr] <= mem_ub_wdata;
    mem_lb_rdata <= lb_mem[mem_lb_addr];
    mem_ub_rdata <= ub_mem[mem_ub_addr];
  end
  initial for (int i = 0; i < 32768; i++) begin lb_mem[i] = 8'h00; ub_mem[i] = 8'h00; end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [7:0] rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction
  task automatic access(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                        input logic cw = 1'b0, input logic [0:0] cs = 1'b0,
                        input logic [15:0] ca = 16'h0, input logic ce = 1'b0);
    logic f, h;
    logic [0:0] hi;
    int k, lbn, ubn;
    k = 0;
    while (!ready && k < 50) begin @(negedge clk); k++; end
    chk("ready_wait", ready, 1);
    f = !b && a[0];
    h = 1'b0;
    hi = '0;
    for (int i = WP - 1; i >= 0; i--)
      if (!f && wv[i] && (wa[i] == a || (!b && wa[i] == (a ^ 16'h1)))) begin h = 1'b1; hi = i[0:0]; end
    if (!f && w) begin
      ref_mem[int'(a)] = d[7:0];
      if (!b) ref_mem[int'(a) + 1] = d[15:8];
    end
    if (!f && !w) last_rd = b ? {8'h00, rd(a)} : {rd(a + 16'h1), rd(a)};
    req = 1'b1; wr = w; byte_en = b; addr = a; wdata = d;
    wp_we = cw; wp_sel = cs; wp_addr = ca; wp_en = ce;
    @(posedge clk); #1;
    req = 1'b0; wp_we = 1'b0;
    if (cw) begin wa[cs] = ca; wv[cs] = ce; end
    @(negedge clk);
    k = 1; lbn = 0; ubn = 0;
    while (!done && k < 50) begin
      if (mem_lb_we) begin
        lbn++;
        chk("lb_addr", mem_lb_addr, a[15:1]);
        chk("lb_wdata", mem_lb_wdata, d[7:0]);
      end
      if (mem_ub_we) begin
        ubn++;
        chk("ub_addr", mem_ub_addr, a[15:1]);
        chk("ub_wdata", mem_ub_wdata, b ? d[7:0] : d[15:8]);
      end
      @(negedge clk); k++;
    end
    chk("latency", k, f ? 1 : WC + 3);
    chk("fault", fault, f);
    chk("rdata", rdata, last_rd);
    chk("wp_hit", wp_hit, h);
    if (h) chk("wp_idx", wp_idx, hi);
    chk("lb_pulses", lbn, (w && !f && (!b || !a[0])) ? 1 : 0);
    chk("ub_pulses", ubn, (w && !f && (!b || a[0])) ? 1 : 0);
    @(negedge clk);
    chk("ready_after", ready, 1);
    chk("done_cleared", done, 0);
  endtask
  task automatic cfg(input logic [0:0] s, input logic [15:0] a, input logic e);
    @(negedge clk);
    wp_we = 1'b1; wp_sel = s; wp_addr = a; wp_en = e;
    @(negedge clk);
    wp_we = 1'b0;
    wa[s] = a; wv[s] = e;
  endtask
  initial begin
    int k, d1, d2, pulses;
    logic r_done, r_next;
    for (int i = 0; i < WP; i++) begin wa[i] = '0; wv[i] = 1'b0; end
    last_rd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wp_idx", wp_idx, 0);
    chk("rst_we", {mem_lb_we, mem_ub_we}, 0);
    access(1, 0, 16'h0010, 16'hBEEF);
    access(0, 0, 16'h0010, 16'h0);
    chk("word_rd", rdata, 16'hBEEF);
    access(1, 1, 16'h0011, 16'h005A);
    access(0, 0, 16'h0010, 16'h0);
    chk("merged_rd", rdata, 16'h5AEF);
    access(0, 1, 16'h0011, 16'h0);
    chk("byte_rd", rdata, 16'h005A);
    access(0, 0, 16'h0013, 16'h0);
    chk("fault_hold", rdata, 16'h005A);
    access(1, 0, 16'h0015, 16'h1234);
    access(1, 1, 16'hFFFF, 16'h00C3);
    access(0, 1, 16'hFFFF, 16'h0);
    access(0, 0, 16'hFFFE, 16'h0);
    // req held high through DONE: second accept only after DONE.
    @(negedge clk);
    req = 1'b1; wr = 1'b0; byte_en = 1'b0; addr = 16'h0010;
    k = 0; d1 = 0; d2 = 0; r_done = 1'b1; r_next = 1'b0;
    while (d2 == 0 && k < 60) begin
      @(negedge clk); k++;
      if (done && d1 == 0) begin d1 = k; r_done = ready; end
      else if (done) d2 = k;
      if (d1 != 0 && k == d1 + 1) r_next = ready;
    end
    req = 1'b0;
    chk("b2b_first_done", d1, WC + 3);
    chk("b2b_second_done", d2, 2 * (WC + 4) - 1);
    chk("b2b_ready_in_done", r_done, 0);
    chk("b2b_ready_after", r_next, 1);
    chk("b2b_rdata", rdata, 16'h5AEF);
    @(negedge clk);
    cfg(0, 16'h0020, 1);
    cfg(1, 16'h0021, 1);
    access(0, 0, 16'h0020, 16'h0);
    access(0, 1, 16'h0021, 16'h0);
    access(0, 1, 16'h0021, 16'h0, 1, 1, 16'h0021, 0);
    access(0, 1, 16'h0021, 16'h0);
    chk("wp1_disabled", wv[1], 0);
    access(1, 1, 16'h0020, 16'h0077);
    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra;
      ra = ($urandom_range(0, 9) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'h0010 + 16'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0)
        access($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ra, 16'($urandom),
               1, 1'($urandom_range(0, 1)), 16'h0010 + 16'($urandom_range(0, 31)), $urandom_range(0, 1) == 1);
      else
        access($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ra, 16'($urandom));
    end
    cfg(0, 16'h0020, 1);
    // Reset in the second ACCESS cycle of a read.
    while (!ready) @(negedge clk);
    req = 1'b1; wr = 1'b0; byte_en = 1'b0; addr = 16'h0020;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < WP; i++) begin wa[i] = '0; wv[i] = 1'b0; end
    last_rd = '0;
    @(negedge clk);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wp_hit", wp_hit, 0);
    chk("mid_rst_bank", {mem_lb_we, mem_ub_we, mem_lb_addr, mem_ub_addr, mem_lb_wdata}, 0);
    pulses = 0;
    for (int i = 0; i < WC + 6; i++) begin @(negedge clk); if (done) pulses++; end
    chk("mid_rst_no_done", pulses, 0);
    access(0, 0, 16'h0020, 16'h0);
    chk("post_rst_no_hit", wp_hit, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory access unit between the XM23 control unit and the split byte-lane memory (even-byte bank LB, odd-byte bank UB). It replaces the hard-wired MAR/MDR transfer with a request/done handshake. It supports word and byte accesses, a configurable number of memory wait states, alignment-fault detection, and `WP_COUNT` programmable data watchpoints. It sits between `control_unit` and `memory`; the MAR/MDR registers live here.

## Interface
Parameters:
- `ADDR_W`, 16, byte address width. Each bank is indexed by `addr[ADDR_W-1:1]`.
- `WAIT_CYCLES`, 0, extra memory wait states per access (0..15).
- `WP_COUNT`, 2, number of watchpoints (1..8). `WPI_W` = max(1, clog2(`WP_COUNT`)).

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `req` in 1: access request.
- `ready` out 1: unit idle; a request is accepted when `req` and `ready` are both high.
- `wr` in 1: 1 = write, 0 = read.
- `byte_en` in 1: 1 = byte access, 0 = word access.
- `addr` in `ADDR_W`: byte address (MAR source).
- `wdata` in 16: write data (MDR source). Byte writes use `[7:0]`.
- `done` out 1: one-cycle completion pulse.
- `fault` out 1: valid with `done`; high when a word access used an odd address.
- `rdata` out 16: read result (MDR). Byte reads are zero-extended. Held until the next read completes.
- `wp_hit` out 1: valid with `done`; high when the access touched a watched byte.
- `wp_idx` out `WPI_W`: lowest-index watchpoint that hit.
- `wp_we` in 1: watchpoint config write strobe.
- `wp_sel` in `WPI_W`: watchpoint being configured.
- `wp_addr` in `ADDR_W`: watch address.
- `wp_en` in 1: watchpoint enable.
- `mem_lb_addr`, `mem_ub_addr` out `ADDR_W-1`: bank word index.
- `mem_lb_wdata`, `mem_ub_wdata` out 8: bank write data.
- `mem_lb_we`, `mem_ub_we` out 1: bank write enables.
- `mem_lb_rdata`, `mem_ub_rdata` in 8: bank read data. The banks are synchronous: the address is registered on the rising edge and data is valid in the following cycle.

## Operation
- States: IDLE, ACCESS, DONE. `ready` = (state == IDLE).
- IDLE:
  - On accept, latch `addr`, `wdata`, `wr` and `byte_en`.
  - If `!byte_en && addr[0]`, go to DONE with `fault` = 1. No bank enables fire, `rdata` is unchanged and `wp_hit` = 0.
  - Otherwise go to ACCESS.
- ACCESS lasts `WAIT_CYCLES`+2 cycles, then goes to DONE. A counter is loaded on entry.
  - Both bank addresses are driven with `latched_addr[ADDR_W-1:1]` for the whole state.
  - Writes: the lane enables are high only in the first ACCESS cycle.
    - Word write: both lanes. LB gets `wdata[7:0]`, UB gets `wdata[15:8]`.
    - Byte write, even address: LB only, data `wdata[7:0]`.
    - Byte write, odd address: UB only, data `wdata[7:0]`.
  - Reads: `rdata` is captured on the edge that leaves ACCESS.
    - Word read: {UB, LB}.
    - Byte read: {8'h00, selected lane}.
  - Writes leave `rdata` unchanged.
- DONE lasts one cycle with `done` = 1, then returns to IDLE. A request presented during DONE is not accepted.
- Watchpoints:
  - Each watchpoint has a register `{en, addr}`.
  - On a `wp_we` edge, watchpoint `wp_sel` loads `wp_addr` and `wp_en`. Values of `wp_sel` >= `WP_COUNT` are ignored.
  - Comparison is made at the accept edge against register values from before that edge. A config write in the same cycle as an accept applies from the next request onward.
  - Word access hits when `wp.addr[ADDR_W-1:1]` == `addr[ADDR_W-1:1]`. Byte access hits on an exact match.
  - A hit does not block the access. `wp_hit`/`wp_idx` are registered and presented during DONE.
- `Reset` (synchronous, valid in any state, including mid-ACCESS):
  - Next state is IDLE.
  - Outputs after the reset edge: `ready` = 1, `done` = `fault` = `wp_hit` = 0, `wp_idx` = 0, `rdata` = 0, both bank enables 0, bank addresses and wdata 0.
  - All watchpoint enables and addresses are cleared.
  - A write interrupted after its enable cycle has already completed in memory. No `done` is issued for it.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- Valid access accepted at edge E0:
  - ACCESS occupies cycles 1..`WAIT_CYCLES`+2.
  - `done` is high in cycle `WAIT_CYCLES`+3.
  - `ready` is high again in cycle `WAIT_CYCLES`+4.
- Faulted access: `done` in cycle 1, `ready` in cycle 2.
- Throughput: one access per `WAIT_CYCLES`+4 cycles.
- Counter width is 5 bits. No wrap is possible within the legal `WAIT_CYCLES` range.
- Bank addresses for `addr` = all-ones byte access: index = all-ones. No +1 carry is ever formed.

## Test plan
- `WAIT_CYCLES`=0, word write 16'hBEEF @ 16'h0010, then word read @ 16'h0010 -> LB enable and UB enable pulse once each with 8'hEF/8'hBE; `rdata` = 16'hBEEF; `done` 3 cycles after each accept; `fault` = 0.
- Byte write 8'h5A @ 16'h0011 over existing 16'hBEEF, then word read @ 16'h0010 -> only `mem_ub_we` fires; `rdata` = 16'h5AEF. Byte read @ 16'h0011 -> `rdata` = 16'h005A.
- Word read @ 16'h0013 -> `done` and `fault` high in cycle 1; no bank enable; `rdata` holds its previous value; `wp_hit` = 0.
- `WAIT_CYCLES`=3: read accepted -> `done` exactly 6 cycles later; `req` held high through DONE is accepted only in the cycle after DONE.
- Watchpoints: wp0 = 16'h0020 and wp1 = 16'h0021, both enabled.
  - Word read @ 16'h0020 -> `wp_hit` = 1, `wp_idx` = 0.
  - Byte read @ 16'h0021 -> `wp_idx` = 1.
  - Disable wp1 in the accept cycle of a byte read @ 16'h0021 -> that access still hits; the next one does not.
- Assert `Reset` in the second ACCESS cycle of a read -> next cycle `ready` = 1, `rdata` = 0, `done` never pulses, watchpoints disabled.
